// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: lock-qualified core reset release, soft reset and PIT clock enable
module clk_rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD = 1024,
  parameter int RST_HOLD = 16,
  parameter int PIT_DIV = 12
) (
  input logic clk,
  input logic rst_n,
  input logic pll_locked,
  input logic soft_rst_req,
  output logic sys_rst,
  output logic sys_rst_n,
  output logic ready,
  output logic pit_ce,
  output logic lock_lost
);
  localparam int CW = $clog2(LOCK_HOLD > RST_HOLD ? LOCK_HOLD : RST_HOLD);
  localparam int DW = $clog2(PIT_DIV);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_HOLD - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_HOLD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIT_DIV - 1);
  localparam logic [1:0] WAIT_LOCK = 2'd0, STABLE = 2'd1, RUN = 2'd2, SOFT_RST = 2'd3;
  logic [SYNC_STAGES-1:0] sync;
  logic [1:0] state, nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic locked_s, run_stay, lost;
  assign locked_s = sync[SYNC_STAGES-1];
  assign run_stay = state == RUN && nxt == RUN;
  assign lost = state == RUN && !locked_s;
  always_comb
    nxt = state == WAIT_LOCK ? (locked_s ? STABLE : WAIT_LOCK) :
          !locked_s ? WAIT_LOCK :
          state == STABLE ? (cnt == LOCK_LAST ? RUN : STABLE) :
          state == RUN ? (soft_rst_req ? SOFT_RST : RUN) :
          cnt == RST_LAST ? RUN : SOFT_RST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      state <= WAIT_LOCK;
      cnt <= '0;
      div <= '0;
      pit_ce <= 1'b0;
      sys_rst <= 1'b1;
      sys_rst_n <= 1'b0;
      ready <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      state <= nxt;
      cnt <= (nxt == state && (state == STABLE || state == SOFT_RST)) ? cnt + 1'b1 : '0;
      div <= run_stay ? (div == DIV_LAST ? '0 : div + 1'b1) : '0;
      pit_ce <= run_stay && div == DIV_LAST;
      sys_rst <= nxt != RUN;
      sys_rst_n <= nxt == RUN;
      ready <= nxt == RUN;
      lock_lost <= lost ? 1'b1 : (state == RUN && nxt == SOFT_RST) ? 1'b0 : lock_lost;
    end
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: scoreboard bench checking reset release, soft reset, lock loss and pit_ce cadence
module tb_clk_rst_sequencer;
  localparam int PIT_DIV = 12;
  typedef struct {
    int e;
    logic [4:0] v;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic pll_locked = 1;
  logic soft_rst_req = 0;
  logic sys_rst, sys_rst_n, ready, pit_ce, lock_lost;
  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  exp_t sb[$];
  clk_rst_sequencer #(
    .SYNC_STAGES(2),
    .LOCK_HOLD(8),
    .RST_HOLD(16),
    .PIT_DIV(PIT_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req),
    .sys_rst(sys_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .pit_ce(pit_ce),
    .lock_lost(lock_lost)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int a, input int b, input logic sr, input logic ll, input int r);
    for (int e = a; e <= b; e++) begin
      logic pce;
      pce = r >= 0 && e > r && (e - r) % PIT_DIV == 0;
      sb.push_back('{e, {sr, !sr, !sr, pce, ll}});
    end
  endtask
  task automatic at(input int t);
    do @(negedge clk); while (cyc < t);
  endtask
  always @(negedge clk) begin
    chk("pit_in_rst", {31'd0, pit_ce & sys_rst}, 32'd0);
    while (sb.size() > 0 && sb[0].e <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      if (x.e < cyc) chk($sformatf("late_e%0d", x.e), cyc, x.e);
      else chk($sformatf("out_e%0d", x.e), {27'd0, sys_rst, sys_rst_n, ready, pit_ce, lock_lost}, {27'd0, x.v});
    end
  end
  initial begin
    push(1, 3, 1, 0, -1);
    at(3);
    rst_n = 1;
    push(4, 13, 1, 0, -1);
    push(14, 52, 0, 0, 14);
    at(52);
    soft_rst_req = 1;
    push(53, 68, 1, 0, -1);
    push(69, 97, 0, 0, 69);
    at(53);
    soft_rst_req = 0;
    at(56);
    soft_rst_req = 1;
    at(57);
    soft_rst_req = 0;
    at(95);
    pll_locked = 0;
    push(98, 115, 1, 1, -1);
    at(105);
    pll_locked = 1;
    push(116, 132, 0, 1, 116);
    at(130);
    pll_locked = 0;
    push(133, 153, 1, 1, -1);
    at(135);
    pll_locked = 1;
    at(140);
    pll_locked = 0;
    at(143);
    pll_locked = 1;
    push(154, 160, 0, 1, 154);
    at(160);
    soft_rst_req = 1;
    push(161, 176, 1, 0, -1);
    push(177, 182, 0, 0, 177);
    at(161);
    soft_rst_req = 0;
    at(180);
    pll_locked = 0;
    at(182);
    soft_rst_req = 1;
    push(183, 200, 1, 1, -1);
    at(183);
    soft_rst_req = 0;
    at(190);
    pll_locked = 1;
    push(201, 205, 0, 1, 201);
    at(205);
    soft_rst_req = 1;
    push(206, 212, 1, 0, -1);
    at(206);
    soft_rst_req = 0;
    at(210);
    rst_n = 0;
    #1;
    chk("async_rst", {27'd0, sys_rst, sys_rst_n, ready, pit_ce, lock_lost}, 32'b10000);
    at(212);
    rst_n = 1;
    push(213, 222, 1, 0, -1);
    push(223, 226, 0, 0, 223);
    at(230);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
